// File: rtl/intersection_sched.sv
// Two-approach phase scheduler: NS/EW green, yellow and all-red clearance,
// pedestrian early termination and rest-on-NS-green when EW is idle.
module intersection_sched #(
    parameter int GREEN_T   = 60,
    parameter int YELLOW_T  = 5,
    parameter int ALLRED_T  = 2,
    parameter int MIN_GREEN = 10,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tick,
    input  logic             ped_req,
    input  logic             ew_demand,
    output logic             ns_red,
    output logic             ns_yellow,
    output logic             ns_green,
    output logic             ew_red,
    output logic             ew_yellow,
    output logic             ew_green,
    output logic [2:0]       phase,
    output logic [CNT_W-1:0] remaining,
    output logic             ped_pending
);

    typedef enum logic [2:0] {
        AR_N = 3'd0,
        NS_G = 3'd1,
        NS_Y = 3'd2,
        AR_E = 3'd3,
        EW_G = 3'd4,
        EW_Y = 3'd5
    } phase_t;

    localparam logic [CNT_W-1:0] G1  = CNT_W'(GREEN_T - 1);
    localparam logic [CNT_W-1:0] Y1  = CNT_W'(YELLOW_T - 1);
    localparam logic [CNT_W-1:0] R1  = CNT_W'(ALLRED_T - 1);
    localparam logic [CNT_W-1:0] MG1 = CNT_W'(MIN_GREEN - 1);

    phase_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             ped_nxt;
    logic             last, wrap, early;

    function automatic logic [CNT_W-1:0] dur_m1(input phase_t p);
        case (p)
            AR_N, AR_E: dur_m1 = R1;
            NS_G, EW_G: dur_m1 = G1;
            default:    dur_m1 = Y1;
        endcase
    endfunction

    // Lamp triple ordered {red, yellow, green}
    function automatic logic [2:0] ns_lamps(input phase_t p);
        case (p)
            NS_G:    ns_lamps = 3'b001;
            NS_Y:    ns_lamps = 3'b010;
            default: ns_lamps = 3'b100;
        endcase
    endfunction

    function automatic logic [2:0] ew_lamps(input phase_t p);
        case (p)
            EW_G:    ew_lamps = 3'b001;
            EW_Y:    ew_lamps = 3'b010;
            default: ew_lamps = 3'b100;
        endcase
    endfunction

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        wrap      = 1'b0;
        last      = (cnt == dur_m1(state));
        early     = ped_pending && (cnt >= MG1);
        if (tick) begin
            case (state)
                AR_N: if (last) state_nxt = NS_G;
                NS_G: begin
                    if (early || (last && ew_demand)) state_nxt = NS_Y;
                    else if (last) wrap = 1'b1;
                end
                NS_Y: if (last) state_nxt = AR_E;
                AR_E: if (last) state_nxt = EW_G;
                EW_G: if (early || last) state_nxt = EW_Y;
                EW_Y: if (last) state_nxt = AR_N;
                default: state_nxt = AR_N;
            endcase
            cnt_nxt = (state_nxt != state || wrap) ? '0 : cnt + 1'b1;
        end
    end

    // A request arriving on the yellow-entry edge must survive the clear
    always_comb begin
        ped_nxt = ped_pending;
        if (state_nxt != state && (state_nxt == NS_Y || state_nxt == EW_Y))
            ped_nxt = 1'b0;
        if (ped_req)
            ped_nxt = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= AR_N;
            cnt         <= '0;
            ped_pending <= 1'b0;
            {ns_red, ns_yellow, ns_green} <= 3'b100;
            {ew_red, ew_yellow, ew_green} <= 3'b100;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            ped_pending <= ped_nxt;
            {ns_red, ns_yellow, ns_green} <= ns_lamps(state_nxt);
            {ew_red, ew_yellow, ew_green} <= ew_lamps(state_nxt);
        end
    end

    assign phase     = state;
    assign remaining = dur_m1(state) - cnt;

endmodule

// File: tb/tb_intersection_sched.sv
// Directed bench for intersection_sched: phase sequencing, ped early end,
// NS rest, async reset and tick freeze, with a continuous lamp-safety check.
module tb_intersection_sched;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tick = 1'b0;
    logic       ped_req = 1'b0;
    logic       ew_demand = 1'b0;
    logic       ns_red, ns_yellow, ns_green;
    logic       ew_red, ew_yellow, ew_green;
    logic [2:0] phase;
    logic [7:0] remaining;
    logic       ped_pending;

    int total = 0;
    int bad   = 0;

    intersection_sched dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .tick       (tick),
        .ped_req    (ped_req),
        .ew_demand  (ew_demand),
        .ns_red     (ns_red),
        .ns_yellow  (ns_yellow),
        .ns_green   (ns_green),
        .ew_red     (ew_red),
        .ew_yellow  (ew_yellow),
        .ew_green   (ew_green),
        .phase      (phase),
        .remaining  (remaining),
        .ped_pending(ped_pending)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Lamp safety, sampled on every falling edge
    always @(negedge clk) begin
        total++;
        assert ($onehot({ns_red, ns_yellow, ns_green})
                && $onehot({ew_red, ew_yellow, ew_green})
                && !((ns_green || ns_yellow) && (ew_green || ew_yellow)))
        else begin
            bad++;
            $error("FAIL lamps observed=%b%b%b_%b%b%b expected=safe",
                   ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green);
        end
    end

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk) tick = 1'b1;
            @(negedge clk) tick = 1'b0;
        end
    endtask

    task automatic do_reset(input logic ew);
        @(negedge clk);
        rst_n = 1'b0;
        tick = 1'b0;
        ped_req = 1'b0;
        ew_demand = ew;
        @(negedge clk);
        @(negedge clk) rst_n = 1'b1;
    endtask

    task automatic ped_pulse();
        @(negedge clk) ped_req = 1'b1;
        @(negedge clk) ped_req = 1'b0;
    endtask

    initial begin
        // 1: full cycle with EW demand
        do_reset(1'b1);
        chk("rst_phase", phase, 0);
        chk("rst_rem", remaining, 1);
        chk("rst_nsr", ns_red, 1);
        chk("rst_ewr", ew_red, 1);
        chk("rst_ped", ped_pending, 0);
        ticks(1);
        chk("arn_hold", phase, 0);
        chk("arn_rem0", remaining, 0);
        ticks(1);
        chk("t2_phase", phase, 1);
        chk("t2_rem", remaining, 59);
        chk("t2_nsg", ns_green, 1);
        ticks(60);
        chk("t62_phase", phase, 2);
        chk("t62_nsy", ns_yellow, 1);
        chk("t62_rem", remaining, 4);
        ticks(5);
        chk("t67_phase", phase, 3);
        chk("t67_nsr", ns_red, 1);
        ticks(2);
        chk("t69_phase", phase, 4);
        chk("t69_ewg", ew_green, 1);
        ticks(60);
        chk("t129_phase", phase, 5);
        chk("t129_ewy", ew_yellow, 1);
        ticks(5);
        chk("t134_phase", phase, 0);
        chk("t134_rem", remaining, 1);

        // 2: ped at NS_G cnt=3 ends green at cnt=9
        do_reset(1'b1);
        ticks(2);
        ticks(3);
        chk("p2_rem", remaining, 56);
        ped_pulse();
        chk("p2_ped", ped_pending, 1);
        ticks(6);
        chk("p2_hold", phase, 1);
        chk("p2_rem9", remaining, 50);
        ticks(1);
        chk("p2_nsy", phase, 2);
        chk("p2_clr", ped_pending, 0);

        // 3: late ped, held across yellow entry; EW_G cut at cnt=9
        do_reset(1'b1);
        ticks(32);
        chk("p3_rem", remaining, 29);
        @(negedge clk) ped_req = 1'b1;
        ticks(1);
        ped_req = 1'b0;
        chk("p3_nsy", phase, 2);
        chk("p3_keep", ped_pending, 1);
        ticks(7);
        chk("p3_ewg", phase, 4);
        chk("p3_ped", ped_pending, 1);
        ticks(9);
        chk("p3_ewhold", phase, 4);
        ticks(1);
        chk("p3_ewy", phase, 5);
        chk("p3_clr", ped_pending, 0);

        // 4: NS rest without demand
        do_reset(1'b0);
        ticks(2);
        for (int k = 0; k < 3; k++) begin
            ticks(60);
            chk("rest_phase", phase, 1);
            chk("rest_rem", remaining, 59);
        end
        ew_demand = 1'b1;
        ticks(59);
        chk("rest_last", phase, 1);
        chk("rest_rem0", remaining, 0);
        ticks(1);
        chk("rest_nsy", phase, 2);

        // 5: async reset during EW_Y
        do_reset(1'b1);
        ticks(131);
        chk("r5_phase", phase, 5);
        chk("r5_rem", remaining, 2);
        ped_pulse();
        chk("r5_ped", ped_pending, 1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("r5_rphase", phase, 0);
        chk("r5_rrem", remaining, 1);
        chk("r5_ped0", ped_pending, 0);
        chk("r5_ewy", ew_yellow, 0);
        chk("r5_nsr", ns_red, 1);
        chk("r5_ewr", ew_red, 1);
        @(negedge clk) rst_n = 1'b1;
        ticks(1);
        chk("r5_t1", phase, 0);
        ticks(1);
        chk("r5_t2", phase, 1);

        // 6: no tick for 1000 clocks freezes outputs
        do_reset(1'b1);
        ticks(9);
        repeat (1000) @(negedge clk);
        chk("frz_phase", phase, 1);
        chk("frz_rem", remaining, 52);
        chk("frz_nsg", ns_green, 1);
        chk("frz_ewr", ew_red, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
